pll_reset_sequencer: RTL and testbench

//  Closes the loop around the system PLL: drives the PLL's reset input and watches its

---
 rtl/pll_reset_sequencer.sv | 127 ++++++++++++
 tb/tb_pll_reset_sequencer.sv | 248 ++++++++++++++++++++++++
 2 files changed

// File: rtl/pll_reset_sequencer.sv
// Sequences the system PLL's reset against its lock flag and releases a registered
// system reset only after lock has been continuously qualified.
module pll_reset_sequencer #(
    parameter int RST_CYCLES    = 16,
    parameter int LOCK_TIMEOUT  = 65536,
    parameter int STABLE_CYCLES = 1024,
    parameter int SYNC_STAGES   = 2,
    parameter int CNT_W         = 8
) (
    input  logic             refclk,
    input  logic             rst,
    input  logic             locked,
    output logic             pll_rst,
    output logic             sys_rst,
    output logic             ready,
    output logic [CNT_W-1:0] timeout_cnt,
    output logic [CNT_W-1:0] lost_cnt
);

    localparam int MAX_AB   = (RST_CYCLES > LOCK_TIMEOUT) ? RST_CYCLES : LOCK_TIMEOUT;
    localparam int MAX_ALL  = (MAX_AB > STABLE_CYCLES) ? MAX_AB : STABLE_CYCLES;
    localparam int CNT_BITS = (MAX_ALL > 1) ? $clog2(MAX_ALL) : 1;

    localparam logic [CNT_BITS-1:0] RST_LAST    = CNT_BITS'(RST_CYCLES - 1);
    localparam logic [CNT_BITS-1:0] TIMEOUT_LAST = CNT_BITS'(LOCK_TIMEOUT - 1);
    localparam logic [CNT_BITS-1:0] STABLE_LAST = CNT_BITS'(STABLE_CYCLES - 1);

    typedef enum logic [1:0] {
        S_PLLRST = 2'd0,
        S_WAIT   = 2'd1,
        S_STABLE = 2'd2,
        S_RUN    = 2'd3
    } state_t;

    state_t                 state_r;
    logic [CNT_BITS-1:0]    cnt_r;
    logic [SYNC_STAGES-1:0] sync_r;
    logic                   locked_s;

    // Status counters stick at all-ones instead of wrapping.
    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        return (v == {CNT_W{1'b1}}) ? v : v + CNT_W'(1);
    endfunction

    assign locked_s = sync_r[SYNC_STAGES-1];

    // Synchroniser bringing the asynchronous lock flag into the refclk domain.
    always_ff @(posedge refclk or posedge rst) begin
        if (rst) begin
            sync_r <= {SYNC_STAGES{1'b0}};
        end else begin
            sync_r <= {sync_r[SYNC_STAGES-2:0], locked};
        end
    end

    // Sequencer state, shared cycle counter and all registered outputs.
    always_ff @(posedge refclk or posedge rst) begin
        if (rst) begin
            state_r     <= S_PLLRST;
            cnt_r       <= {CNT_BITS{1'b0}};
            pll_rst     <= 1'b1;
            sys_rst     <= 1'b1;
            ready       <= 1'b0;
            timeout_cnt <= {CNT_W{1'b0}};
            lost_cnt    <= {CNT_W{1'b0}};
        end else begin
            case (state_r)
                S_PLLRST: begin
                    if (cnt_r == RST_LAST) begin
                        state_r <= S_WAIT;
                        cnt_r   <= {CNT_BITS{1'b0}};
                        pll_rst <= 1'b0;
                    end else begin
                        cnt_r <= cnt_r + CNT_BITS'(1);
                    end
                end
                S_WAIT: begin
                    // Lock takes priority over a coincident timeout.
                    if (locked_s) begin
                        state_r <= S_STABLE;
                        cnt_r   <= {CNT_BITS{1'b0}};
                    end else if (cnt_r == TIMEOUT_LAST) begin
                        state_r     <= S_PLLRST;
                        cnt_r       <= {CNT_BITS{1'b0}};
                        pll_rst     <= 1'b1;
                        timeout_cnt <= sat_inc(timeout_cnt);
                    end else begin
                        cnt_r <= cnt_r + CNT_BITS'(1);
                    end
                end
                S_STABLE: begin
                    if (!locked_s) begin
                        state_r <= S_WAIT;
                        cnt_r   <= {CNT_BITS{1'b0}};
                    end else if (cnt_r == STABLE_LAST) begin
                        state_r <= S_RUN;
                        cnt_r   <= {CNT_BITS{1'b0}};
                        sys_rst <= 1'b0;
                        ready   <= 1'b1;
                    end else begin
                        cnt_r <= cnt_r + CNT_BITS'(1);
                    end
                end
                S_RUN: begin
                    if (!locked_s) begin
                        state_r  <= S_PLLRST;
                        cnt_r    <= {CNT_BITS{1'b0}};
                        pll_rst  <= 1'b1;
                        sys_rst  <= 1'b1;
                        ready    <= 1'b0;
                        lost_cnt <= sat_inc(lost_cnt);
                    end else begin
                        cnt_r <= {CNT_BITS{1'b0}};
                    end
                end
                default: begin
                    state_r <= S_PLLRST;
                    cnt_r   <= {CNT_BITS{1'b0}};
                    pll_rst <= 1'b1;
                    sys_rst <= 1'b1;
                    ready   <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_pll_reset_sequencer.sv
// Scoreboard bench: the driver pushes expected outputs from a countdown-based lock
// sequencing model; a monitor pops and compares one entry per refclk cycle.
module tb_pll_reset_sequencer;

    localparam int RST_CYCLES    = 4;
    localparam int LOCK_TIMEOUT  = 32;
    localparam int STABLE_CYCLES = 8;
    localparam int SYNC_STAGES   = 2;
    localparam int CNT_W         = 8;
    localparam int SAT_MAX       = (1 << CNT_W) - 1;

    logic             refclk = 1'b0;
    logic             rst    = 1'b1;
    logic             locked = 1'b0;
    logic             pll_rst;
    logic             sys_rst;
    logic             ready;
    logic [CNT_W-1:0] timeout_cnt;
    logic [CNT_W-1:0] lost_cnt;

    typedef struct packed {
        logic             pll_rst;
        logic             sys_rst;
        logic             ready;
        logic [CNT_W-1:0] tcnt;
        logic [CNT_W-1:0] lcnt;
    } obs_t;

    obs_t exp_q[$];
    int   n_checks = 0;
    int   n_fail   = 0;
    int   cyc      = 0;

    pll_reset_sequencer #(
        .RST_CYCLES   (RST_CYCLES),
        .LOCK_TIMEOUT (LOCK_TIMEOUT),
        .STABLE_CYCLES(STABLE_CYCLES),
        .SYNC_STAGES  (SYNC_STAGES),
        .CNT_W        (CNT_W)
    ) dut (
        .refclk     (refclk),
        .rst        (rst),
        .locked     (locked),
        .pll_rst    (pll_rst),
        .sys_rst    (sys_rst),
        .ready      (ready),
        .timeout_cnt(timeout_cnt),
        .lost_cnt   (lost_cnt)
    );

    always #5 refclk = ~refclk;

    // Reference model: phases with remaining-cycle budgets and a delay line for sync lag.
    localparam int P_PLLRST = 0;
    localparam int P_WAIT   = 1;
    localparam int P_QUAL   = 2;
    localparam int P_RUN    = 3;

    int   m_phase = P_PLLRST;
    int   m_rem   = RST_CYCLES;
    int   m_tcnt  = 0;
    int   m_lcnt  = 0;
    logic m_line[$];

    function automatic void model_reset();
        m_phase = P_PLLRST;
        m_rem   = RST_CYCLES;
        m_tcnt  = 0;
        m_lcnt  = 0;
        m_line.delete();
        for (int i = 0; i < SYNC_STAGES; i++) m_line.push_back(1'b0);
    endfunction

    function automatic void model_step(input logic lk);
        logic ls;
        ls = m_line.pop_front();
        m_line.push_back(lk);
        case (m_phase)
            P_PLLRST: begin
                m_rem--;
                if (m_rem == 0) begin m_phase = P_WAIT; m_rem = LOCK_TIMEOUT; end
            end
            P_WAIT: begin
                if (ls) begin
                    m_phase = P_QUAL; m_rem = STABLE_CYCLES;
                end else begin
                    m_rem--;
                    if (m_rem == 0) begin
                        m_tcnt  = (m_tcnt < SAT_MAX) ? m_tcnt + 1 : SAT_MAX;
                        m_phase = P_PLLRST; m_rem = RST_CYCLES;
                    end
                end
            end
            P_QUAL: begin
                if (!ls) begin
                    m_phase = P_WAIT; m_rem = LOCK_TIMEOUT;
                end else begin
                    m_rem--;
                    if (m_rem == 0) m_phase = P_RUN;
                end
            end
            P_RUN: begin
                if (!ls) begin
                    m_lcnt  = (m_lcnt < SAT_MAX) ? m_lcnt + 1 : SAT_MAX;
                    m_phase = P_PLLRST; m_rem = RST_CYCLES;
                end
            end
            default: ;
        endcase
    endfunction

    function automatic obs_t model_out();
        obs_t e;
        e.pll_rst = (m_phase == P_PLLRST);
        e.sys_rst = (m_phase != P_RUN);
        e.ready   = (m_phase == P_RUN);
        e.tcnt    = CNT_W'(m_tcnt);
        e.lcnt    = CNT_W'(m_lcnt);
        return e;
    endfunction

    function automatic obs_t observe();
        obs_t o;
        o.pll_rst = pll_rst;
        o.sys_rst = sys_rst;
        o.ready   = ready;
        o.tcnt    = timeout_cnt;
        o.lcnt    = lost_cnt;
        return o;
    endfunction

    task automatic check_obs(input string name, input obs_t got, input obs_t req);
        n_checks++;
        if (got !== req) begin
            n_fail++;
            $display("FAIL %s cycle %0d: got pll_rst=%b sys_rst=%b ready=%b timeout_cnt=%0d lost_cnt=%0d, required pll_rst=%b sys_rst=%b ready=%b timeout_cnt=%0d lost_cnt=%0d",
                     name, cyc, got.pll_rst, got.sys_rst, got.ready, got.tcnt, got.lcnt,
                     req.pll_rst, req.sys_rst, req.ready, req.tcnt, req.lcnt);
        end
    endtask

    task automatic check_bit(input string name, input logic got, input logic req);
        n_checks++;
        if (got !== req) begin
            n_fail++;
            $display("FAIL %s cycle %0d: got %b, required %b", name, cyc, got, req);
        end
    endtask

    // Drive one cycle at the falling edge and queue what the next rising edge must produce.
    task automatic cycle(input logic lk, input logic r);
        logic was_rst;
        obs_t rst_vals;
        @(negedge refclk);
        was_rst = rst;
        locked  = lk;
        rst     = r;
        if (r) model_reset();
        else   model_step(lk);
        exp_q.push_back(model_out());
        if (r && !was_rst) begin
            rst_vals = '{pll_rst: 1'b1, sys_rst: 1'b1, ready: 1'b0,
                         tcnt: {CNT_W{1'b0}}, lcnt: {CNT_W{1'b0}}};
            #1;
            check_obs("async_reset", observe(), rst_vals);
        end
    endtask

    // Monitor: one expected entry per rising edge, plus the output invariants.
    initial begin
        obs_t e;
        forever begin
            @(posedge refclk);
            #1;
            cyc++;
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                check_obs("outputs", observe(), e);
                check_bit("sys_rst_eq_not_ready", sys_rst, ~ready);
                if (pll_rst) check_bit("pll_rst_implies_sys_rst", sys_rst, 1'b1);
            end
        end
    end

    initial begin
        model_reset();
        repeat (3) cycle(1'b0, 1'b1);

        // Lock present from release: one pulse, then qualification to ready.
        repeat (30) cycle(1'b1, 1'b0);

        // No lock: periodic PLL re-reset and timeout counting.
        repeat (3 * (RST_CYCLES + LOCK_TIMEOUT) + 5) cycle(1'b0, 1'b0);

        // Reach run, lose lock for one cycle, re-qualify.
        repeat (20) cycle(1'b1, 1'b0);
        cycle(1'b0, 1'b0);
        repeat (30) cycle(1'b1, 1'b0);

        // Single-cycle drops at every point through qualification, each started by rst.
        for (int off = 3; off <= 16; off++) begin
            cycle(1'b1, 1'b1);
            repeat (off) cycle(1'b1, 1'b0);
            cycle(1'b0, 1'b0);
            repeat (22) cycle(1'b1, 1'b0);
        end

        // Timeout saturation.
        cycle(1'b0, 1'b1);
        repeat (300 * (RST_CYCLES + LOCK_TIMEOUT) + 10) cycle(1'b0, 1'b0);
        @(posedge refclk);
        #2;
        check_bit("timeout_saturated", timeout_cnt == CNT_W'(SAT_MAX), 1'b1);

        // Lost-lock saturation.
        cycle(1'b1, 1'b1);
        for (int i = 0; i < 270; i++) begin
            repeat (16) cycle(1'b1, 1'b0);
            cycle(1'b0, 1'b0);
        end
        @(posedge refclk);
        #2;
        check_bit("lost_saturated", lost_cnt == CNT_W'(SAT_MAX), 1'b1);

        // Random lock runs with occasional rst in arbitrary states.
        for (int i = 0; i < 120; i++) begin
            int   len;
            logic v;
            len = $urandom_range(1, 40);
            v   = ($urandom_range(0, 3) != 0);
            repeat (len) cycle(v, 1'b0);
            if ($urandom_range(0, 7) == 0) cycle(v, 1'b1);
        end

        // Drain the scoreboard with a bounded wait.
        for (int i = 0; i < 10 && exp_q.size() > 0; i++) @(posedge refclk);
        #2;
        n_checks++;
        if (exp_q.size() != 0) begin
            n_fail++;
            $display("FAIL drain: got %0d entries left, required 0", exp_q.size());
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
